// File: rtl/gbe_rx_frame_buffer.sv
// Store-and-forward RX frame buffer behind the 100G core yellow-block RX port.
// Only complete good frames are released; bad, oversize and overrun frames are dropped.
module gbe_rx_frame_buffer #(
    parameter int DATA_W  = 512,
    parameter int FIFO_AW = 6
) (
    input  logic              user_clk,
    input  logic              gbe_rst_n,
    input  logic [DATA_W-1:0] gbe_rx_data,
    input  logic              gbe_rx_valid,
    input  logic              gbe_rx_end_of_frame,
    input  logic              gbe_rx_bad_frame,
    input  logic              gbe_rx_overrun,
    output logic              gbe_rx_ack,
    output logic              gbe_rx_overrun_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [31:0]       frame_count,
    output logic [31:0]       drop_count,
    output logic [31:0]       overrun_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0] PTR_FULL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP,
        RECOVER
    } state_t;

    state_t state;

    logic [DATA_W:0] mem [DEPTH];

    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] commit_ptr;
    logic [FIFO_AW:0] rd_ptr;

    logic full;
    logic empty;
    logic ovr_take;
    logic rx_open;
    logic mem_we;

    logic            s1_valid;
    logic [DATA_W:0] s1_word;
    logic            out_load;
    logic            s1_adv;
    logic            rd_en;

    assign gbe_rx_ack = gbe_rx_valid;

    // Full is taken against rd_ptr so committed words are never overwritten.
    assign full     = (wr_ptr - rd_ptr) == PTR_FULL;
    assign empty    = rd_ptr == commit_ptr;
    assign ovr_take = gbe_rx_overrun && (state != RECOVER);
    assign rx_open  = (state == IDLE) || (state == RECV);
    assign mem_we   = gbe_rx_valid && rx_open && !full && !ovr_take;

    always_ff @(posedge user_clk) begin
        if (mem_we) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {gbe_rx_end_of_frame, gbe_rx_data};
        end
    end

    always_ff @(posedge user_clk or negedge gbe_rst_n) begin
        if (!gbe_rst_n) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            commit_ptr         <= '0;
            frame_count        <= '0;
            drop_count         <= '0;
            overrun_count      <= '0;
            gbe_rx_overrun_ack <= 1'b0;
        end else begin
            gbe_rx_overrun_ack <= 1'b0;
            // Overrun wins over any eof seen in the same cycle.
            if (ovr_take) begin
                wr_ptr             <= commit_ptr;
                overrun_count      <= overrun_count + 32'd1;
                gbe_rx_overrun_ack <= 1'b1;
                state              <= RECOVER;
            end else begin
                unique case (state)
                    IDLE, RECV: begin
                        if (gbe_rx_valid) begin
                            if (full) begin
                                wr_ptr <= commit_ptr;
                                if (gbe_rx_end_of_frame) begin
                                    drop_count <= drop_count + 32'd1;
                                    state      <= IDLE;
                                end else begin
                                    state <= DROP;
                                end
                            end else if (!gbe_rx_end_of_frame) begin
                                wr_ptr <= wr_ptr + PTR_ONE;
                                state  <= RECV;
                            end else if (gbe_rx_bad_frame) begin
                                wr_ptr     <= commit_ptr;
                                drop_count <= drop_count + 32'd1;
                                state      <= IDLE;
                            end else begin
                                wr_ptr      <= wr_ptr + PTR_ONE;
                                commit_ptr  <= wr_ptr + PTR_ONE;
                                frame_count <= frame_count + 32'd1;
                                state       <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (gbe_rx_valid && gbe_rx_end_of_frame) begin
                            drop_count <= drop_count + 32'd1;
                            state      <= IDLE;
                        end
                    end
                    RECOVER: begin
                        if (!gbe_rx_overrun) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Two-stage read path: memory read register, then the visible output register.
    assign out_load = !out_valid || out_ready;
    assign s1_adv   = s1_valid && out_load;
    assign rd_en    = !empty && (!s1_valid || s1_adv);

    always_ff @(posedge user_clk or negedge gbe_rst_n) begin
        if (!gbe_rst_n) begin
            rd_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_word   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (rd_en) begin
                s1_word <= mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            s1_valid <= rd_en || (s1_valid && !s1_adv);
            if (out_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    {out_last, out_data} <= s1_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_gbe_rx_frame_buffer.sv
// Directed scoreboard bench for gbe_rx_frame_buffer.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_gbe_rx_frame_buffer;

    localparam int DW = 512;

    logic          user_clk;
    logic          gbe_rst_n;
    logic [DW-1:0] gbe_rx_data;
    logic          gbe_rx_valid;
    logic          gbe_rx_end_of_frame;
    logic          gbe_rx_bad_frame;
    logic          gbe_rx_overrun;
    logic          gbe_rx_ack;
    logic          gbe_rx_overrun_ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [31:0]   frame_count;
    logic [31:0]   drop_count;
    logic [31:0]   overrun_count;

    gbe_rx_frame_buffer #(.DATA_W(DW), .FIFO_AW(6)) dut (
        .user_clk            (user_clk),
        .gbe_rst_n           (gbe_rst_n),
        .gbe_rx_data         (gbe_rx_data),
        .gbe_rx_valid        (gbe_rx_valid),
        .gbe_rx_end_of_frame (gbe_rx_end_of_frame),
        .gbe_rx_bad_frame    (gbe_rx_bad_frame),
        .gbe_rx_overrun      (gbe_rx_overrun),
        .gbe_rx_ack          (gbe_rx_ack),
        .gbe_rx_overrun_ack  (gbe_rx_overrun_ack),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_last            (out_last),
        .out_ready           (out_ready),
        .frame_count         (frame_count),
        .drop_count          (drop_count),
        .overrun_count       (overrun_count)
    );

    int checks = 0;
    int passes = 0;
    int ack_cycles = 0;
    logic [DW:0] exp_q[$];

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge user_clk) begin
        if (gbe_rst_n && gbe_rx_overrun_ack) ack_cycles++;
    end

    always @(negedge user_clk) begin
        if (gbe_rst_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_word: unexpected word last=%0b data=%0h, none required",
                         out_last, out_data[31:0]);
            end else if ({out_last, out_data} !== exp_q[0]) begin
                $display("FAIL out_word: got last=%0b data=%0h, required last=%0b data=%0h",
                         out_last, out_data[31:0], exp_q[0][DW], exp_q[0][31:0]);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                passes++;
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic do_reset();
        gbe_rst_n           = 1'b0;
        gbe_rx_valid        = 1'b0;
        gbe_rx_end_of_frame = 1'b0;
        gbe_rx_bad_frame    = 1'b0;
        gbe_rx_overrun      = 1'b0;
        gbe_rx_data         = '0;
        exp_q.delete();
        repeat (2) @(posedge user_clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_counts", 64'(frame_count | drop_count | overrun_count), 64'd0);
        chk("rst_ovr_ack", 64'(gbe_rx_overrun_ack), 64'd0);
        ack_cycles = 0;
        gbe_rst_n = 1'b1;
        @(posedge user_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic eof, input logic bad);
        gbe_rx_data         = '0;
        gbe_rx_data[31:0]   = d;
        gbe_rx_valid        = 1'b1;
        gbe_rx_end_of_frame = eof;
        gbe_rx_bad_frame    = bad;
        #1;
        chk("rx_ack_hi", 64'(gbe_rx_ack), 64'd1);
        @(posedge user_clk);
        #1;
        gbe_rx_valid        = 1'b0;
        gbe_rx_end_of_frame = 1'b0;
        gbe_rx_bad_frame    = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        logic [DW:0] w;
        w = '0;
        w[31:0] = d;
        w[DW] = last;
        exp_q.push_back(w);
    endtask

    task automatic frame(input logic [31:0] base, input int len,
                         input logic bad, input logic good);
        for (int i = 0; i < len; i++) begin
            if (good) push(base + 32'(i), i == len - 1);
        end
        for (int i = 0; i < len; i++) begin
            send(base + 32'(i), i == len - 1, bad && (i == len - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge user_clk);
            #1;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        idle(4);
    endtask

    logic [3:0] pat;

    initial begin
        out_ready = 1'b1;
        pat = 4'b1001;
        do_reset();

        // 1: 4-word good frame, latency and ack
        push(1, 0); push(2, 0); push(3, 0); push(4, 1);
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 0);
        chk("t1_ack_lo", 64'(gbe_rx_ack), 64'd0);
        chk("t1_valid_e0", 64'(out_valid), 64'd0);
        idle(1);
        chk("t1_valid_e1", 64'(out_valid), 64'd0);
        idle(1);
        chk("t1_valid_e2", 64'(out_valid), 64'd1);
        drain("t1_drain");
        chk("t1_frames", 64'(frame_count), 64'd1);

        // 2: bad frame then good frame
        do_reset();
        frame(32'h20, 3, 1, 0);
        frame(32'h30, 2, 0, 1);
        drain("t2_drain");
        chk("t2_drops", 64'(drop_count), 64'd1);
        chk("t2_frames", 64'(frame_count), 64'd1);

        // 3: oversize frame dropped via full, then 1-word frame
        do_reset();
        out_ready = 1'b0;
        frame(32'h100, 70, 0, 0);
        frame(32'hAA, 1, 0, 1);
        idle(5);
        chk("t3_drops", 64'(drop_count), 64'd1);
        chk("t3_frames", 64'(frame_count), 64'd1);
        chk("t3_stalled_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain("t3_drain");

        // 4: overrun for 5 cycles from word 2
        do_reset();
        send(32'h41, 0, 0);
        gbe_rx_overrun = 1'b1;
        send(32'h42, 0, 0); send(32'h43, 0, 0); send(32'h44, 0, 0);
        send(32'h45, 0, 0); send(32'h46, 1, 0);
        gbe_rx_overrun = 1'b0;
        idle(2);
        frame(32'h50, 3, 0, 1);
        drain("t4_drain");
        chk("t4_ovr_count", 64'(overrun_count), 64'd1);
        chk("t4_ack_cycles", 64'(ack_cycles), 64'd1);
        chk("t4_frames", 64'(frame_count), 64'd1);
        chk("t4_drops", 64'(drop_count), 64'd0);

        // 5: backpressure 1,0,0,1 while a second frame arrives
        do_reset();
        out_ready = 1'b0;
        frame(32'h60, 8, 0, 1);
        for (int i = 0; i < 8; i++) push(32'h70 + 32'(i), i == 7);
        fork
            for (int i = 0; i < 8; i++) send(32'h70 + 32'(i), i == 7, 0);
            for (int k = 0; k < 40; k++) begin
                out_ready = pat[k % 4];
                @(posedge user_clk);
                #1;
            end
        join
        out_ready = 1'b1;
        drain("t5_drain");
        chk("t5_frames", 64'(frame_count), 64'd2);

        // 6: overrun together with a good eof
        do_reset();
        send(32'h81, 0, 0);
        gbe_rx_overrun = 1'b1;
        send(32'h82, 1, 0);
        gbe_rx_overrun = 1'b0;
        idle(3);
        chk("t6_frames", 64'(frame_count), 64'd0);
        chk("t6_ovr_count", 64'(overrun_count), 64'd1);
        chk("t6_ack_cycles", 64'(ack_cycles), 64'd1);
        frame(32'h90, 2, 0, 1);
        drain("t6_drain");
        chk("t6_frames_after", 64'(frame_count), 64'd1);

        // 7: reset mid-frame discards the partial frame
        do_reset();
        send(32'hA1, 0, 0); send(32'hA2, 0, 0);
        do_reset();
        frame(32'hB0, 1, 0, 1);
        drain("t7_drain");
        chk("t7_frames", 64'(frame_count), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gbe_rx_frame_buffer.md
Name: gbe_rx_frame_buffer

Overview:
- User-side consumer of the 100G core's yellow-block RX interface.
- Acknowledges every received word.
- Buffers each frame store-and-forward.
- Releases only complete, good frames to a downstream AXI-stream-style port.
- Drops bad, oversize and overrun-truncated frames, runs the overrun/overrun-ack handshake, and keeps frame/drop/overrun statistics.

Parameters:
- DATA_W, 512, width of gbe_rx_data and out_data.
- FIFO_AW, 6, log2 of buffer depth in words; depth = 2^FIFO_AW = 64.

Ports:
- user_clk  in  1  sole clock, the core's streaming data clock.
- gbe_rst_n  in  1  asynchronous active-low reset.
- gbe_rx_data  in  DATA_W  received word.
- gbe_rx_valid  in  1  word valid.
- gbe_rx_end_of_frame  in  1  last word of frame; qualified by gbe_rx_valid.
- gbe_rx_bad_frame  in  1  frame error; sampled with end_of_frame.
- gbe_rx_overrun  in  1  core RX overrun flag; level.
- gbe_rx_ack  out  1  word acknowledge to the core.
- gbe_rx_overrun_ack  out  1  overrun acknowledge pulse.
- out_data  out  DATA_W  buffered word.
- out_valid  out  1  out_data valid.
- out_last  out  1  last word of frame.
- out_ready  in  1  downstream accept.
- frame_count  out  32  good frames committed.
- drop_count  out  32  frames discarded (bad or full).
- overrun_count  out  32  overrun events.

Behaviour:
- Reset: all outputs are 0 and all pointers are 0; state is IDLE.
- Reset asserted mid-frame discards the buffer contents and any partial frame.
- Storage: 2^FIFO_AW entries of {eof, data}.
- Pointers are FIFO_AW+1 bits wide, with MSB wrap:
  - wr_ptr: speculative write pointer.
  - commit_ptr: end of the last good frame.
  - rd_ptr: read pointer.
- Full is true when wr_ptr - rd_ptr == 2^FIFO_AW.
- Empty toward the reader is true when rd_ptr == commit_ptr.
- gbe_rx_ack = gbe_rx_valid (combinational). The source is never stalled; words that cannot be stored are discarded.
- State machine:
  - IDLE/RECV, valid & !full: write the word and increment wr_ptr. Without eof, go to RECV.
  - Valid with eof & !bad (full permitting): commit with commit_ptr <= wr_ptr+1, frame_count+1, go to IDLE. A single-word frame in IDLE is legal.
  - Valid with eof & bad: wr_ptr <= commit_ptr, drop_count+1, go to IDLE.
  - Valid & full: wr_ptr <= commit_ptr. If eof is also set, drop_count+1 and go to IDLE; otherwise go to DROP.
  - DROP: discard words. On valid & eof, drop_count+1 and go to IDLE.
  - Any state, gbe_rx_overrun=1, while not already in RECOVER:
    - wr_ptr <= commit_ptr; overrun_count+1.
    - gbe_rx_overrun_ack=1 for exactly one cycle, on the next cycle.
    - Go to RECOVER.
    - Overrun has priority over a simultaneous eof/commit; that frame is lost and counted only as an overrun.
  - RECOVER: discard words. When gbe_rx_overrun=0, go to IDLE. Nothing is re-acked while overrun stays high.
- Output stage: a first-word-fall-through register fed from the memory.
  - out_valid rises 2 cycles after the edge that samples a committing eof, provided the register was empty.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - Transfer happens on out_valid & out_ready; the next word follows back-to-back with no bubble.
- A commit and a pop in the same cycle are both performed.
- A frame longer than 2^FIFO_AW words can never commit and is always dropped via full.
- Committed words are never overwritten. Full is measured against rd_ptr.
- All counters are 32-bit and wrap from 0xFFFFFFFF to 0.

Test Plan:
1. Reset, then a 4-word good frame (data = 1,2,3,4, eof on word 4) with out_ready=1:
   - gbe_rx_ack is high for 4 cycles.
   - out_valid rises 2 cycles after eof; out_data = 1,2,3,4 with out_last only on 4.
   - frame_count=1.
2. 3-word frame with bad_frame on eof, then a 2-word good frame:
   - Only the 2 good words appear on the output.
   - drop_count=1, frame_count=1.
3. out_ready=0 and a 70-word frame:
   - Full is hit at 64 words and the frame is dropped; drop_count=1.
   - A following 1-word frame is output correctly after out_ready=1.
4. Overrun asserted for 5 cycles during word 2 of a frame:
   - gbe_rx_overrun_ack pulses once, 1 cycle.
   - overrun_count=1 and no output from that frame.
   - The next good frame is delivered intact.
5. Backpressure: out_ready toggling 1,0,0,1 over a committed 8-word frame while a second frame is being received:
   - All 16 words arrive in order with no duplication or loss.
   - out_data is stable while stalled.
6. Overrun asserted in the same cycle as a good eof:
   - The frame is dropped; frame_count is unchanged and overrun_count=1.
